mult_radix4_seq: RTL and testbench

MULT_RADIX4_SEQ -- requirements
Module: mult_radix4_seq

---
 rtl/mult_pkg.sv | 20 ++
 rtl/mux4to1_wide.sv | 23 ++
 rtl/mult_radix4_seq.sv | 153 +++++++++++++++
 tb/tb_mult_radix4_seq.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential radix-4 multiplier.
package mult_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_ITER,
    ST_FIX,
    ST_DONE
  } state_e;

  localparam int unsigned MULT_WIDTH = 32;
  localparam int unsigned ITERS      = MULT_WIDTH / 2;

  // Two multiplier bits are retired per iteration.
  function automatic int unsigned iters_for(input int unsigned width);
    return width / 2;
  endfunction

endpackage

// File: rtl/mux4to1_wide.sv
// Parameterised 4:1 selector picking one of {0, M, 2M, 3M} partial products.
module mux4to1_wide #(
  parameter int unsigned W = 34
) (
  input  logic [W-1:0] d0_i,
  input  logic [W-1:0] d1_i,
  input  logic [W-1:0] d2_i,
  input  logic [W-1:0] d3_i,
  input  logic [1:0]   sel_i,
  output logic [W-1:0] y_o
);

  always_comb begin
    y_o = d0_i;
    case (sel_i)
      2'd1:    y_o = d1_i;
      2'd2:    y_o = d2_i;
      2'd3:    y_o = d3_i;
      default: y_o = d0_i;
    endcase
  end

endmodule

// File: rtl/mult_radix4_seq.sv
// Sequential radix-4 (2 bits/cycle) signed/unsigned multiplier producing a
// 2*WIDTH product split into Hi/Lo; sign handled by magnitude + final negate.
module mult_radix4_seq
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int unsigned NITER = iters_for(WIDTH);
  localparam int unsigned CW    = (NITER > 1) ? $clog2(NITER) : 1;
  localparam int unsigned MW    = WIDTH + 2;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             mode_q, mode_d;
  logic             sign_q, sign_d;
  logic [MW-1:0]    m_q, m_d, m3_q, m3_d, acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  logic [WIDTH-1:0]   mag_a_c, mag_b_c;
  logic [MW-1:0]      m2_c, sel_c;
  logic [MW:0]        sum_c;
  logic [2*WIDTH-1:0] prod_c, fixed_c;
  logic               unused_acc_c;

  // Negating the most negative value yields 2^(WIDTH-1), which is exact as unsigned.
  assign mag_a_c = (mode_q & a_q[WIDTH-1]) ? WIDTH'(-a_q) : a_q;
  assign mag_b_c = (mode_q & b_q[WIDTH-1]) ? WIDTH'(-b_q) : b_q;
  assign m2_c    = {m_q[MW-2:0], 1'b0};

  mux4to1_wide #(.W(MW)) u_sel (
    .d0_i  ('0),
    .d1_i  (m_q),
    .d2_i  (m2_c),
    .d3_i  (m3_q),
    .sel_i (q_q[1:0]),
    .y_o   (sel_c)
  );

  // Single accumulator adder; the carry-out is kept as the new top bit.
  assign sum_c   = {1'b0, acc_q} + {1'b0, sel_c};
  assign prod_c  = {acc_q[WIDTH-1:0], q_q};
  assign fixed_c = (mode_q & sign_q) ? (2*WIDTH)'(-prod_c) : prod_c;
  assign unused_acc_c = ^acc_q[MW-1:WIDTH];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    sign_d  = sign_q;
    m_d     = m_q;
    m3_d    = m3_q;
    acc_d   = acc_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          a_d     = A;
          b_d     = B;
          mode_d  = Signed;
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        m_d     = MW'(mag_a_c);
        m3_d    = MW'(mag_a_c) + (MW'(mag_a_c) << 1);
        sign_d  = a_q[WIDTH-1] ^ b_q[WIDTH-1];
        acc_d   = '0;
        q_d     = mag_b_c;
        cnt_d   = '0;
        state_d = ST_ITER;
      end
      ST_ITER: begin
        acc_d = MW'(sum_c[MW:2]);
        q_d   = {sum_c[1:0], q_q[WIDTH-1:2]};
        cnt_d = CW'(cnt_q + 1'b1);
        if (cnt_q == CW'(NITER - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        hi_d    = fixed_c[2*WIDTH-1:WIDTH];
        lo_d    = fixed_c[WIDTH-1:0];
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Flags are registered from the next state so they align with it.
    busy_d = (state_d == ST_PREP) || (state_d == ST_ITER) || (state_d == ST_FIX);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      sign_q  <= 1'b0;
      m_q     <= '0;
      m3_q    <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      sign_q  <= sign_d;
      m_q     <= m_d;
      m3_q    <= m3_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign Hi   = hi_q;
  assign Lo   = lo_q;

endmodule

// File: tb/tb_mult_radix4_seq.sv
// Self-checking bench for mult_radix4_seq: cycle-level behavioural model with
// a 64-bit arithmetic reference, directed literal vectors and a random sweep.
module tb_mult_radix4_seq;

  localparam int unsigned W   = 32;
  localparam int          LAT = W / 2 + 3;

  logic         clk = 1'b0;
  logic         rst_n, start, sgn;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  always #5 clk = ~clk;

  mult_radix4_seq #(.WIDTH(W)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .Start   (start),
    .Signed  (sgn),
    .A       (a),
    .B       (b),
    .Busy    (busy),
    .Done    (done),
    .Hi      (hi),
    .Lo      (lo)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference product using plain 64-bit arithmetic.
  function automatic logic [63:0] ref_prod(input logic s, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy;
    logic [63:0]        ux, uy;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'h0, x};
    uy = {32'h0, y};
    if (s) return $unsigned(sx * sy);
    return ux * uy;
  endfunction

  // Behavioural model: an accepted request completes LAT edges later.
  bit          m_init = 1'b0;
  bit          m_active = 1'b0;
  bit          m_prev_done = 1'b0;
  int          m_age = 0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [63:0] m_pend = '0;
  logic [63:0] m_res = '0;
  int          m_done_cnt = 0;
  int          dut_done_cnt = 0;
  int          n_exp_done = 0;
  longint      edge_cnt = 0;

  always @(posedge clk) begin
    edge_cnt++;
    if (!rst_n) begin
      m_init   = 1'b1;
      m_active = 1'b0;
      m_age    = 0;
      m_busy   = 1'b0;
      m_done   = 1'b0;
      m_res    = '0;
    end else begin
      m_prev_done = m_done;
      m_done      = 1'b0;
      if (m_active) begin
        m_age++;
        if (m_age == LAT) begin
          m_active = 1'b0;
          m_busy   = 1'b0;
          m_done   = 1'b1;
          m_res    = m_pend;
          m_done_cnt++;
        end
      end else if (start && !m_prev_done) begin
        m_active = 1'b1;
        m_age    = 1;
        m_busy   = 1'b1;
        m_pend   = ref_prod(sgn, a, b);
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("busy", 64'(busy), 64'(m_busy));
      check("done", 64'(done), 64'(m_done));
      check("hi", 64'(hi), 64'(m_res[63:32]));
      check("lo", 64'(lo), 64'(m_res[31:0]));
      if (done) dut_done_cnt++;
    end
  end

  task automatic launch(input logic s, input logic [31:0] x, input logic [31:0] y, output longint e);
    @(negedge clk);
    start = 1'b1;
    sgn   = s;
    a     = x;
    b     = y;
    @(negedge clk);
    e     = edge_cnt;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    sgn   = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input longint e, input string name);
    bit seen;
    int lat;
    seen = 1'b0;
    for (int i = 0; i < LAT + 20; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    lat = seen ? int'(edge_cnt - e + 1) : -1;
    check({name, "_latency"}, 64'(lat), 64'(LAT));
  endtask

  task automatic do_op(input logic s, input logic [31:0] x, input logic [31:0] y, input string name);
    longint e;
    launch(s, x, y, e);
    n_exp_done++;
    wait_done(e, name);
    check({name, "_prod"}, {hi, lo}, ref_prod(s, x, y));
  endtask

  task automatic lit_op(input logic s, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] exp, input string name);
    check({name, "_ref"}, ref_prod(s, x, y), exp);
    do_op(s, x, y, name);
    check({name, "_lit"}, {hi, lo}, exp);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint      e;
    logic        rs;
    logic [31:0] rx, ry;
    logic [31:0] corners [6];
    corners[0] = 32'h0000_0000;
    corners[1] = 32'hFFFF_FFFF;
    corners[2] = 32'h8000_0000;
    corners[3] = 32'h7FFF_FFFF;
    corners[4] = 32'h0000_0001;
    corners[5] = 32'h5555_5555;

    rst_n = 1'b0;
    start = 1'b0;
    sgn   = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;

    lit_op(1'b0, 32'd3,         32'd5,         64'h0000_0000_0000_000F, "u3x5");
    lit_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "umax");
    lit_op(1'b1, 32'hFFFF_FFFD, 32'd5,         64'hFFFF_FFFF_FFFF_FFF1, "s_m3x5");
    lit_op(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "s_min2");
    lit_op(1'b1, 32'h8000_0000, 32'd1,         64'hFFFF_FFFF_8000_0000, "s_minx1");
    lit_op(1'b0, 32'h8000_0000, 32'd2,         64'h0000_0001_0000_0000, "u_halfx2");
    lit_op(1'b0, 32'd0,         32'd0,         64'h0,                   "zero");
    lit_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h1,                   "s_m1xm1");
    lit_op(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, "s_maxxmin");

    // Second Start during the operation must be dropped.
    launch(1'b0, 32'd7, 32'd9, e);
    n_exp_done++;
    while (edge_cnt - e + 1 < 4) @(negedge clk);
    start = 1'b1;
    sgn   = 1'b0;
    a     = 32'd100;
    b     = 32'd100;
    @(negedge clk);
    start = 1'b0;
    wait_done(e, "repulse");
    check("repulse_lit", {hi, lo}, 64'd63);

    // Start held high: the Done-cycle request is ignored, the next idle one is taken.
    @(negedge clk);
    start = 1'b1;
    sgn   = 1'b0;
    a     = 32'd11;
    b     = 32'd13;
    repeat (LAT + 3) @(negedge clk);
    start = 1'b0;
    n_exp_done += 2;
    repeat (LAT + 2) @(negedge clk);
    check("hold_lit", {hi, lo}, 64'd143);

    // Reset in the middle of an operation aborts it and clears the result.
    launch(1'b0, 32'd123, 32'd456, e);
    while (edge_cnt - e + 1 < 9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstmid_busy", 64'(busy), 64'd0);
    check("rstmid_done", 64'(done), 64'd0);
    check("rstmid_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    repeat (LAT + 5) @(negedge clk);
    lit_op(1'b1, 32'hFFFF_FFFE, 32'h10, 64'hFFFF_FFFF_FFFF_FFE0, "after_rst");

    // Reset wins over a simultaneous Start.
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b1;
    @(negedge clk);
    check("rstprio_busy", 64'(busy), 64'd0);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rstprio_idle", 64'(busy), 64'd0);

    for (int i = 0; i < 2000; i++) begin
      rs = 1'($urandom_range(0, 1));
      rx = $urandom;
      ry = $urandom;
      if (i % 7 == 0) rx = corners[$urandom_range(0, 5)];
      if (i % 5 == 0) ry = corners[$urandom_range(0, 5)];
      do_op(rs, rx, ry, "rand");
    end

    repeat (3) @(negedge clk);
    check("done_count_dut", 64'(dut_done_cnt), 64'(m_done_cnt));
    check("done_count_model", 64'(m_done_cnt), 64'(n_exp_done));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
